// File: rtl/lab.sv
// lab: sequential signed WIDTH x WIDTH multiplier, radix-4 Booth recoding.
// Operands load on every edge with reset=1; WIDTH/2 Booth steps follow,
// then out/out_valid present the 2*WIDTH-bit product until the next reset.
// Optional build macro LAB_OUT_LIVE_EN: out follows the partial accumulator
// during BUSY (still qualified by out_valid); the final value is unchanged.
module lab #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid
);

    // acc = {upper field (WIDTH+2), multiplier bits (WIDTH), Booth guard bit}
    localparam int unsigned UW = WIDTH + 2;
    localparam int unsigned AW = 2 * WIDTH + 3;
    localparam int unsigned CW = $clog2(WIDTH / 2) + 1;

    typedef enum logic {
        BUSY = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [UW-1:0]       mcand_q, mcand_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  out_q, out_d;
    logic                valid_q, valid_d;

    logic [UW-1:0]       addend;
    logic [UW-1:0]       upper_sum;
    logic [AW-1:0]       acc_sum;
    logic [AW-1:0]       acc_shift;

    // One Booth step: select +-0/M/2M from acc[2:0], add into upper field, shift right by 2
    always_comb begin
        addend = '0;
        unique case (acc_q[2:0])
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = mcand_q << 1;
            3'b100:         addend = ~(mcand_q << 1) + UW'(1);
            3'b101, 3'b110: addend = ~mcand_q + UW'(1);
            default:        addend = '0;
        endcase
        upper_sum = acc_q[AW-1:WIDTH+1] + addend;
        acc_sum   = {upper_sum, acc_q[WIDTH:0]};
        acc_shift = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    end

    // Next-state logic: reset reloads operands; BUSY iterates; DONE holds
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (reset) begin
            mcand_d = {{2{in_a[WIDTH-1]}}, in_a};
            acc_d   = {{UW{1'b0}}, in_b, 1'b0};
            cnt_d   = '0;
            state_d = BUSY;
            out_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                BUSY: begin
                    acc_d = acc_shift;
                    cnt_d = cnt_q + CW'(1);
`ifdef LAB_OUT_LIVE_EN
                    out_d = acc_shift[2*WIDTH:1];
`endif
                    if (cnt_q == CW'(WIDTH / 2 - 1)) begin
                        out_d   = acc_shift[2*WIDTH:1];
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                end
                default: state_d = DONE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        mcand_q <= mcand_d;
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        valid_q <= valid_d;
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_lab.sv
// tb_lab: directed self-checking bench for the radix-4 Booth multiplier lab.
module tb_lab;

    logic        CLK;
    logic        reset;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [63:0] out;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    lab #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .out       (out),
        .out_valid (out_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reset edge with operands, then expect 15 quiet cycles, valid on the 16th, then hold
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int unsigned hold);
        bit early;
        in_a  = a;
        in_b  = b;
        reset = 1'b1;
        @(posedge CLK); #1;
        check({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rst_out"}, out, 64'd0);
        reset = 1'b0;
        in_a  = 32'hDEAD_BEEF;
        in_b  = 32'h1234_5678;
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK); #1;
            if (out_valid !== 1'b0 || out !== 64'd0) early = 1'b1;
        end
        check({tag, "_busy_quiet"}, 64'(early), 64'd0);
        @(posedge CLK); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out"}, out, exp);
        if (hold > 0) begin
            for (int i = 0; i < int'(hold); i++) @(posedge CLK);
            #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_out"}, out, exp);
        end
    endtask

    initial begin
        bit seen;
        reset = 1'b0;
        in_a  = '0;
        in_b  = '0;
        @(negedge CLK);

        run("p30x90",  32'd30,          32'd90,          64'd2700,                  18);
        run("p30xm90", 32'd30,          -32'sd90,        64'hFFFF_FFFF_FFFF_F574,  0);
        run("m30x90",  -32'sd30,        32'd90,          64'hFFFF_FFFF_FFFF_F574,  0);
        run("m30xm90", -32'sd30,        -32'sd90,        64'd2700,                  0);
        run("minxmin", 32'h8000_0000,   32'h8000_0000,   64'h4000_0000_0000_0000,  0);
        run("maxxmin", 32'h7FFF_FFFF,   32'h8000_0000,   64'hC000_0000_8000_0000,  0);
        run("zeroxm1", 32'd0,           32'hFFFF_FFFF,   64'd0,                     0);
        run("maxxmax", 32'h7FFF_FFFF,   32'h7FFF_FFFF,   64'h3FFF_FFFF_0000_0001,  0);
        run("m1xm1",   32'hFFFF_FFFF,   32'hFFFF_FFFF,   64'd1,                     0);
        run("p1xm1",   32'd1,           32'hFFFF_FFFF,   64'hFFFF_FFFF_FFFF_FFFF,  0);

        // Multi-cycle reset keeps reloading: last operands win
        in_a  = 32'd1000;
        in_b  = 32'd1000;
        reset = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("hold_rst_valid", 64'(out_valid), 64'd0);
        run("longrst", 32'd6, 32'd7, 64'd42, 0);

        // Abort: start 30*90, restart after 7 busy cycles with -5*7
        in_a  = 32'd30;
        in_b  = 32'd90;
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort_pre_valid", 64'(seen), 64'd0);
        run("abort", -32'sd5, 32'd7, 64'hFFFF_FFFF_FFFF_FFDD, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: always terminate
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
